// File: rtl/bitcol_pkg.sv
// bitcol_pkg: shared constants, column-control struct and column-walk helper
// for the bit-column weight issuer (bitcol_sched) and its lane picker.
package bitcol_pkg;

    localparam int BC_DATA_WIDTH    = 8;
    localparam int BC_VEC_LENGTH    = 16;
    localparam int BC_NUM_SLOTS     = BC_VEC_LENGTH / 2;
    localparam int BC_MUX_SEL_WIDTH = $clog2(BC_VEC_LENGTH) + 1;
    localparam int BC_COL_W         = $clog2(BC_DATA_WIDTH);
    localparam int BC_POP_W         = $clog2(BC_VEC_LENGTH + 1);

    // All-ones select: the MAC mux yields 0 for this index.
    localparam logic [BC_MUX_SEL_WIDTH-1:0] SEL_NONE = '1;

    typedef struct packed {
        logic [BC_COL_W-1:0] col_idx;
        logic                is_msb;
        logic                is_skip_zero;
        logic                last;
    } col_ctrl_t;

    // Lowest set bit of nz at or above 'from'. The MSB of nz is always set,
    // so the search cannot fall off the top.
    function automatic logic [BC_COL_W-1:0] next_set(input logic [BC_DATA_WIDTH-1:0] nz,
                                                     input logic [BC_COL_W-1:0]      from);
        next_set = BC_COL_W'(BC_DATA_WIDTH - 1);
        for (int i = BC_DATA_WIDTH - 1; i >= 0; i--)
            if (nz[i] && i >= int'(from)) next_set = BC_COL_W'(i);
    endfunction

endpackage

// File: rtl/bitcol_lane_pick.sv
// bitcol_lane_pick: combinational lane compactor for one bit column.
//   mask   : VEC_LENGTH-bit column (bit i = lane i)
//   invert : select the 0-bit lanes instead of the 1-bit lanes
//   pop    : popcount of the raw (uninverted) mask
//   sel    : NUM_SLOTS lane indices, ascending lane order, padded with SEL_NONE
module bitcol_lane_pick
    import bitcol_pkg::*;
#(
    parameter int VEC_LENGTH    = BC_VEC_LENGTH,
    parameter int NUM_SLOTS     = VEC_LENGTH / 2,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1,
    parameter int POP_W         = $clog2(VEC_LENGTH + 1)
) (
    input  logic [VEC_LENGTH-1:0]                    mask,
    input  logic                                     invert,
    output logic [POP_W-1:0]                         pop,
    output logic [NUM_SLOTS-1:0][MUX_SEL_WIDTH-1:0]  sel
);

    logic [VEC_LENGTH-1:0] pick;
    logic [POP_W-1:0]      rank;

    // Popcount is of the raw mask so the caller can derive invert from it
    // without a combinational loop.
    always_comb begin
        pop = '0;
        for (int i = 0; i < VEC_LENGTH; i++) pop = pop + POP_W'(mask[i]);
    end

    assign pick = invert ? ~mask : mask;

    // Each picked lane lands in the slot equal to the number of picked lanes
    // below it; lanes ranked past the last slot are dropped (the caller
    // guarantees at most NUM_SLOTS picks).
    always_comb begin
        rank = '0;
        sel  = {NUM_SLOTS{SEL_NONE}};
        for (int i = 0; i < VEC_LENGTH; i++) begin
            if (pick[i]) begin
                for (int s = 0; s < NUM_SLOTS; s++)
                    if (rank == POP_W'(s)) sel[s] = MUX_SEL_WIDTH'(i);
                rank = rank + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitcol_sched.sv
// bitcol_sched: weight-side issuer for the bit-column MAC datapath.
// Latches one vector of signed weights and walks its bit columns LSB->MSB,
// one column per cycle, skipping all-zero columns below the MSB. For each
// column the smaller lane group (1-bits or 0-bits) is driven on act_sel;
// the column controls follow one cycle later, aligned with mac_en.
//   clk, reset     : clock, synchronous active-high reset
//   w_valid/w_ready/w_data : weight vector handshake
//   hold           : freeze issue (stage 1 and act_sel)
//   act_sel        : MAC activation-select slots (SEL_NONE = unused)
//   column_idx, is_msb, is_skip_zero, mac_en, vec_done : stage-2 controls
//   busy           : a vector is in flight
module bitcol_sched
    import bitcol_pkg::*;
#(
    parameter int DATA_WIDTH    = BC_DATA_WIDTH,
    parameter int VEC_LENGTH    = BC_VEC_LENGTH,
    parameter int NUM_SLOTS     = VEC_LENGTH / 2,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    w_valid,
    output logic                                    w_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   w_data,
    input  logic                                    hold,
    output logic [NUM_SLOTS-1:0][MUX_SEL_WIDTH-1:0] act_sel,
    output logic [2:0]                              column_idx,
    output logic                                    is_msb,
    output logic                                    is_skip_zero,
    output logic                                    mac_en,
    output logic                                    vec_done,
    output logic                                    busy
);

    localparam int STAGES = 2;
    localparam int POP_W  = $clog2(VEC_LENGTH + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                                  state, state_nxt;
    logic [BC_COL_W-1:0]                     c_q, c_nxt;
    logic                                    load_w;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   w_q;
    logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]   col_ones, col_in;
    logic [DATA_WIDTH-1:0]                   nz, nz_in;
    logic [POP_W-1:0]                        pop;
    logic                                    invert, last, accept;
    logic [NUM_SLOTS-1:0][MUX_SEL_WIDTH-1:0] pick_sel;
    col_ctrl_t                               s1_ctrl, s2_ctrl;
    logic [STAGES:1]                         vld_pipe;

    // Transpose lanes into bit columns, for both the latched vector and the
    // incoming one (the latter picks the first column at accept time).
    for (genvar c = 0; c < DATA_WIDTH; c++) begin : g_col
        for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_lane
            assign col_ones[c][i] = w_q[i][c];
            assign col_in[c][i]   = w_data[i][c];
        end
        if (c == DATA_WIDTH - 1) begin : g_msb
            assign nz[c]    = 1'b1;
            assign nz_in[c] = 1'b1;
        end else begin : g_low
            assign nz[c]    = |col_ones[c];
            assign nz_in[c] = |col_in[c];
        end
    end

    bitcol_lane_pick #(
        .VEC_LENGTH    (VEC_LENGTH),
        .NUM_SLOTS     (NUM_SLOTS),
        .MUX_SEL_WIDTH (MUX_SEL_WIDTH),
        .POP_W         (POP_W)
    ) u_pick (
        .mask   (col_ones[c_q]),
        .invert (invert),
        .pop    (pop),
        .sel    (pick_sel)
    );

    // Exactly NUM_SLOTS ones still fits, so that case keeps the 1-bit lanes.
    assign invert  = pop > POP_W'(NUM_SLOTS);
    assign last    = (c_q == BC_COL_W'(DATA_WIDTH - 1));
    assign w_ready = !hold && (state == IDLE || (state == ISSUE && last));
    assign accept  = w_valid && w_ready;

    always_comb begin
        state_nxt = state;
        c_nxt     = c_q;
        load_w    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_w    = 1'b1;
                    c_nxt     = next_set(nz_in, '0);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    if (last) begin
                        // Back-to-back vectors: the next one starts issuing
                        // on the following cycle with no bubble.
                        if (accept) begin
                            load_w = 1'b1;
                            c_nxt  = next_set(nz_in, '0);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        c_nxt = next_set(nz, c_q + 1'b1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            c_q      <= '0;
            w_q      <= '0;
            act_sel  <= {NUM_SLOTS{SEL_NONE}};
            s1_ctrl  <= '0;
            s2_ctrl  <= '0;
            vld_pipe <= '0;
        end else begin
            state <= state_nxt;
            c_q   <= c_nxt;
            if (load_w) w_q <= w_data;
            // Stage 1: frozen under hold so the MAC re-latches the same selects.
            if (!hold) begin
                vld_pipe[1] <= (state == ISSUE);
                if (state == ISSUE) begin
                    act_sel <= pick_sel;
                    s1_ctrl <= '{col_idx: c_q, is_msb: last, is_skip_zero: !invert, last: last};
                end
            end
            // Stage 2: a held column is not accumulated; it is retried when
            // hold drops, matching the MAC's re-latched selects.
            vld_pipe[2] <= vld_pipe[1] && !hold;
            if (vld_pipe[1] && !hold) s2_ctrl <= s1_ctrl;
        end
    end

    assign mac_en       = vld_pipe[2];
    assign vec_done     = vld_pipe[2] && s2_ctrl.last;
    assign column_idx   = s2_ctrl.col_idx;
    assign is_msb       = s2_ctrl.is_msb;
    assign is_skip_zero = s2_ctrl.is_skip_zero;
    assign busy         = (state == ISSUE) || (|vld_pipe);

endmodule

// File: tb/tb_bitcol_sched.sv
// tb_bitcol_sched: directed + randomized checks of bitcol_sched against a
// column-list reference model built from the weight vector's bit columns.
module tb_bitcol_sched;

    localparam int VL = 16;
    localparam int DW = 8;
    localparam int NS = 8;
    localparam int SW = 5;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   w_valid = 1'b0;
    logic                   hold = 1'b0;
    logic [VL-1:0][DW-1:0]  w_data = '0;
    logic                   w_ready;
    logic [NS-1:0][SW-1:0]  act_sel;
    logic [2:0]             column_idx;
    logic                   is_msb, is_skip_zero, mac_en, vec_done, busy;

    bitcol_sched dut (
        .clk          (clk),
        .reset        (reset),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .hold         (hold),
        .act_sel      (act_sel),
        .column_idx   (column_idx),
        .is_msb       (is_msb),
        .is_skip_zero (is_skip_zero),
        .mac_en       (mac_en),
        .vec_done     (vec_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                col;
        logic              skz;
        logic              first;
        logic [NS*SW-1:0]  sel;
        int                acc_cyc;
    } exp_t;

    exp_t             exp_q[$];
    int               cyc = 0, n_chk = 0, n_pass = 0, n_fail = 0;
    int               mac_cnt = 0, done_cnt = 0, first_mac = -1, last_mac = -1;
    logic             last_acc = 1'b0;
    int               last_acc_cyc = 0;
    logic [NS*SW-1:0] prev_sel = '1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list every column that should issue, with the lane group
    // the MAC should see, straight from the bit-column rules.
    task automatic build(input logic [VL-1:0][DW-1:0] w, input int acc_cyc);
        bit first = 1'b1;
        for (int c = 0; c < DW; c++) begin
            int ones[$];
            int zeros[$];
            int lanes[$];
            exp_t r;
            for (int i = 0; i < VL; i++)
                if (w[i][c]) ones.push_back(i); else zeros.push_back(i);
            if (ones.size() == 0 && c != DW - 1) continue;
            r.col   = c;
            r.skz   = (ones.size() <= NS);
            lanes   = r.skz ? ones : zeros;
            r.sel   = '1;
            for (int k = 0; k < lanes.size(); k++) r.sel[k*SW +: SW] = SW'(lanes[k]);
            r.first = first;
            r.acc_cyc = acc_cyc;
            first   = 1'b0;
            exp_q.push_back(r);
        end
    endtask

    function automatic int ncols(input logic [VL-1:0][DW-1:0] w);
        int n = 1;
        for (int c = 0; c < DW - 1; c++) begin
            bit any = 1'b0;
            for (int i = 0; i < VL; i++) any |= w[i][c];
            n += int'(any);
        end
        return n;
    endfunction

    // One clock: note an accept, advance, then check stage-2 outputs against
    // the next expected column and the selects the MAC latched on this edge.
    task automatic step();
        logic acc;
        acc = w_valid && w_ready;
        if (acc) build(w_data, cyc + 1);
        @(posedge clk);
        cyc++;
        #1;
        if (acc) begin
            last_acc     = 1'b1;
            last_acc_cyc = cyc;
        end
        if (mac_en) begin
            mac_cnt++;
            if (first_mac < 0) first_mac = cyc;
            last_mac = cyc;
            if (vec_done) done_cnt++;
            if (exp_q.size() == 0) begin
                chk("mac_unexpected", 1, 0);
            end else begin
                exp_t r;
                r = exp_q.pop_front();
                chk("column_idx", 64'(column_idx), 64'(r.col));
                chk("is_msb", 64'(is_msb), 64'(r.col == DW - 1));
                chk("is_skip_zero", 64'(is_skip_zero), 64'(r.skz));
                chk("vec_done", 64'(vec_done), 64'(r.col == DW - 1));
                chk("act_sel", 64'(prev_sel), 64'(r.sel));
                if (r.first) chk("first_latency", 64'(cyc), 64'(r.acc_cyc + 2));
            end
        end else begin
            chk("done_without_mac", 64'(vec_done), 0);
        end
        prev_sel = act_sel;
    endtask

    task automatic send(input logic [VL-1:0][DW-1:0] w);
        w_data   = w;
        w_valid  = 1'b1;
        last_acc = 1'b0;
        for (int k = 0; k < 50 && !last_acc; k++) step();
        w_valid = 1'b0;
        chk("accept", 64'(last_acc), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) step();
        chk("drain", 64'(exp_q.size()), 0);
        step();
        step();
    endtask

    task automatic clr_stats();
        mac_cnt = 0; done_cnt = 0; first_mac = -1; last_mac = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VL-1:0][DW-1:0] v, v2;
        logic [NS*SW-1:0]      held;
        int                    acc1, n1;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_act_sel", 64'(act_sel), 64'({NS*SW{1'b1}}));
        chk("rst_mac_en", 64'(mac_en), 0);
        chk("rst_vec_done", 64'(vec_done), 0);
        chk("rst_column_idx", 64'(column_idx), 0);
        chk("rst_is_msb", 64'(is_msb), 0);
        chk("rst_is_skip_zero", 64'(is_skip_zero), 0);
        chk("rst_busy", 64'(busy), 0);
        reset    = 1'b0;
        prev_sel = act_sel;
        #1;
        chk("rst_w_ready", 64'(w_ready), 1);

        // All weights 8'h01: column 0 (inverted, empty) then MSB (empty).
        clr_stats();
        for (int i = 0; i < VL; i++) v[i] = 8'h01;
        send(v);
        drain();
        chk("ones01_mac_cnt", 64'(mac_cnt), 2);
        chk("ones01_done_cnt", 64'(done_cnt), 1);

        // Lane 0 = 8'h81: only columns 0 and 7.
        clr_stats();
        v = '0;
        v[0] = 8'h81;
        send(v);
        drain();
        chk("c81_mac_cnt", 64'(mac_cnt), 2);

        // Lanes 0..8 = 8'h04: column 2 has 9 ones -> zero lanes 9..15.
        v = '0;
        for (int i = 0; i <= 8; i++) v[i] = 8'h04;
        send(v);
        drain();

        // Randomized vectors, alternating dense and sparse.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < VL; i++)
                v[i] = (n % 2 == 0) ? DW'($urandom) : DW'($urandom & $urandom & $urandom);
            send(v);
            drain();
        end

        // Hold for 3 cycles mid-vector.
        for (int i = 0; i < VL; i++) v[i] = DW'($urandom);
        v[0] = 8'hFF;
        send(v);
        step();
        step();
        held = act_sel;
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_act_sel", 64'(act_sel), 64'(held));
            chk("hold_mac_en", 64'(mac_en), 0);
            chk("hold_w_ready", 64'(w_ready), 0);
        end
        hold = 1'b0;
        drain();

        // Back-to-back vectors with w_valid held high.
        clr_stats();
        for (int i = 0; i < VL; i++) begin
            v[i]  = DW'($urandom & $urandom);
            v2[i] = DW'($urandom);
        end
        n1 = ncols(v);
        send(v);
        acc1 = last_acc_cyc;
        send(v2);
        chk("b2b_accept_cycle", 64'(last_acc_cyc), 64'(acc1 + n1));
        drain();
        chk("b2b_contiguous", 64'(last_mac - first_mac + 1), 64'(mac_cnt));
        chk("b2b_mac_cnt", 64'(mac_cnt), 64'(n1 + ncols(v2)));
        chk("b2b_done_cnt", 64'(done_cnt), 2);

        // Reset while column 3 is accumulating.
        for (int i = 0; i < VL; i++) v[i] = DW'($urandom);
        v[0] = 8'hFF;
        send(v);
        for (int k = 0; k < 20 && !(mac_en && column_idx == 3'd3); k++) step();
        chk("reach_col3", 64'(mac_en && column_idx == 3'd3), 1);
        reset = 1'b1;
        exp_q.delete();
        step();
        chk("midrst_mac_en", 64'(mac_en), 0);
        chk("midrst_act_sel", 64'(act_sel), 64'({NS*SW{1'b1}}));
        chk("midrst_w_ready", 64'(w_ready), 1);
        chk("midrst_busy", 64'(busy), 0);
        reset = 1'b0;
        drain();

        // Recovery after reset.
        for (int i = 0; i < VL; i++) v[i] = DW'($urandom);
        send(v);
        drain();
        chk("end_busy", 64'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bitcol_sched.md
Name: bitcol_sched

Overview:
- Weight-side issuer for the bit-column MAC datapath (mac_unit_16_Vert).
- Accepts one vector of VEC_LENGTH signed weights and walks its bit columns LSB to MSB.
- Per column it picks whichever group is smaller, 1-bits or 0-bits, and drives the MAC's activation-select slots plus the column controls with the one-cycle skew the MAC needs.
- Skips all-zero non-MSB columns. sum_act, hamming_* and mul_const are supplied elsewhere.

Parameters:
- DATA_WIDTH, 8, weight width; also the number of bit columns.
- VEC_LENGTH, 16, weights per vector.
- NUM_SLOTS, VEC_LENGTH/2, MAC activation-select slots.
- MUX_SEL_WIDTH, $clog2(VEC_LENGTH)+1, select-index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- w_valid  in  1  weight vector offered
- w_ready  out  1  vector accepted when w_valid && w_ready
- w_data  in  VEC_LENGTH x DATA_WIDTH  signed weights, lane i = w_data[i]
- hold  in  1  freeze issue; no state advances
- act_sel  out  NUM_SLOTS x MUX_SEL_WIDTH  slot lane indices; all-ones = unused (MAC mux yields 0)
- column_idx  out  3  bit position of the column being accumulated
- is_msb  out  1  column is bit DATA_WIDTH-1
- is_skip_zero  out  1  1: slots hold 1-bit lanes; 0: slots hold 0-bit lanes
- mac_en  out  1  MAC accumulate enable
- vec_done  out  1  pulse coincident with the last mac_en of a vector
- busy  out  1  stage 1 or stage 2 valid

Behaviour:
- Reset values:
  - act_sel: all slots all-ones.
  - column_idx, is_msb, is_skip_zero, mac_en, vec_done, busy: 0.
  - Weights and FSM state cleared.
  - w_ready = 1 from the first cycle after reset deasserts.
  - A reset mid-vector discards the vector; no further mac_en for it.
- Column mask:
  - col_ones[c] = bit c of every lane (VEC_LENGTH bits).
  - nz[c] = |col_ones[c]; nz[MSB] is forced to 1, so every vector issues at least one column.
- Column choice:
  - popcount(col_ones[c]) <= NUM_SLOTS: is_skip_zero=1; slots get lanes with bit=1.
  - Otherwise: is_skip_zero=0; slots get lanes with bit=0, which number fewer than NUM_SLOTS.
  - Lanes fill slots 0..k-1 in ascending lane order; slots k..NUM_SLOTS-1 are all-ones.
  - popcount exactly NUM_SLOTS → is_skip_zero=1.
- FSM (stage 1):
  - IDLE: w_ready=1. On accept, latch w_data, set c = lowest set bit of nz, go ISSUE.
  - ISSUE, hold=0: register act_sel for column c and pass {c, is_msb, is_skip_zero, last} to stage 2. Advance c to the next set nz bit above c.
  - ISSUE, after the last column: w_ready=1 in the same cycle. A simultaneous accept starts the next vector with no bubble; otherwise go IDLE.
  - hold=1: stage 1 and act_sel frozen (the MAC re-latches the same selects); w_ready=0.
- Stage 2:
  - Registered copy of stage-1 controls, one cycle after the matching act_sel.
  - mac_en=1 when stage 2 is valid and hold was 0 on the cycle it loaded.
  - vec_done=mac_en&&last.
  - column_idx, is_msb, is_skip_zero hold their last values when mac_en=0.
- Latency:
  - Accept at cycle T → first act_sel at T+1 → first mac_en at T+2.
  - One column per cycle thereafter.
  - A vector with N issued columns ends its mac_en run at T+1+N.

Decomposition:
- Package bitcol_pkg holds:
  - SEL_NONE (all-ones select).
  - Column-control struct {col_idx, is_msb, is_skip_zero, last}.
  - Width localparams.
- Sub-module bitcol_lane_pick (combinational):
  - Inputs: VEC_LENGTH-bit lane mask, invert flag.
  - Outputs: popcount, and NUM_SLOTS compacted lane indices padded with SEL_NONE.

Test Plan:
- All weights 8'h01 → one column issued for c=0: ones=16, so is_skip_zero=0, all slots SEL_NONE. Then MSB column with is_skip_zero=1, slots empty. mac_en on T+2 and T+3; vec_done at T+3.
- Lane0=8'h81, others 0 → column 0: slot0=0, is_skip_zero=1. Columns 1..6 skipped. Column 7: slot0=0, is_msb=1. mac_en on exactly 2 cycles, column_idx 0 then 7.
- Lanes 0..8 = 8'h04, others 0 → column 2 popcount 9 → is_skip_zero=0, slots = lanes 9..15, slot7 = SEL_NONE.
- hold asserted for 3 cycles mid-vector → act_sel stable, mac_en=0 throughout. On release, column order resumes with none lost or duplicated.
- Two vectors with w_valid held high → second accepted on the last ISSUE cycle of the first. mac_en continuous with no gap; vec_done pulses once per vector.
- reset asserted during column 3 of a vector → next cycle: mac_en=0, act_sel all SEL_NONE, w_ready=1, busy=0.
